// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Imported by the interface, the winner picker and the arbiter top.
package bus_arb_pkg;

  localparam int NUM_MASTERS     = 2;
  localparam int TIMEOUT_DEFAULT = 15;
  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 8;
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef logic [0:0] master_idx_t;

  function automatic master_idx_t onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
    return master_idx_t'(oh[1]);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the memory.
// slave: arbiter view; master: view of the requesters plus the memory model.
interface bus_arbiter_if;
  import bus_arb_pkg::*;

  logic [NUM_MASTERS-1:0]        m_req;
  logic [NUM_MASTERS-1:0]        m_we;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]        m_gnt;
  logic [NUM_MASTERS-1:0]        m_done;
  logic [DATA_W-1:0]             m_rdata;
  logic                          m_err;
  logic [ADDR_W-1:0]             mem_addr;
  logic [DATA_W-1:0]             mem_wdata;
  logic [DATA_W-1:0]             mem_rdata;
  logic                          mem_r;
  logic                          mem_w;
  logic                          mem_ready;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, mem_rdata, mem_ready,
    output m_gnt, m_done, m_rdata, m_err, mem_addr, mem_wdata, mem_r, mem_w
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, mem_rdata, mem_ready,
    input  m_gnt, m_done, m_rdata, m_err, mem_addr, mem_wdata, mem_r, mem_w
  );

endinterface

// File: rtl/bus_arb_pick.sv
// One-hot winner selection among pending requests.
// BUS_ARB_ROUND_ROBIN_EN: alternate on contention; otherwise master 0 always wins.
module bus_arb_pick
  import bus_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  master_idx_t            last,
  output logic [NUM_MASTERS-1:0] winner
);

`ifdef BUS_ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = '0;
    if (req == 2'b11) begin
      winner = (last == 1'b1) ? 2'b01 : 2'b10;
    end else begin
      winner = req;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    winner = '0;
    if (req[0]) begin
      winner = 2'b01;
    end else if (req[1]) begin
      winner = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Two-master single-port memory arbiter: IDLE -> ACCESS -> DONE, with ready timeout.
// Policy selected by BUS_ARB_ROUND_ROBIN_EN (defined: round-robin, else fixed priority).
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic          clk,
  input logic          reset,
  bus_arbiter_if.slave bus
);

  state_t                 state_q, state_n;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_n;
  logic [NUM_MASTERS-1:0] done_q, done_n;
  logic [NUM_MASTERS-1:0] winner;
  logic                   err_q, err_n;
  logic                   rd_q, rd_n;
  logic                   wr_q, wr_n;
  logic [ADDR_W-1:0]      addr_q, addr_n;
  logic [DATA_W-1:0]      wdata_q, wdata_n;
  logic [DATA_W-1:0]      rdata_q, rdata_n;
  logic [CNT_W-1:0]       cnt_q, cnt_n;
  master_idx_t            win_idx;
  master_idx_t            last_q;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  master_idx_t            last_n;
`else
  assign last_q = 1'b1;
`endif

  bus_arb_pick u_pick (
    .req    (bus.m_req),
    .last   (last_q),
    .winner (winner)
  );

  assign win_idx = onehot_to_idx(winner);

  always_comb begin
    state_n = state_q;
    gnt_n   = gnt_q;
    done_n  = '0;
    err_n   = 1'b0;
    rd_n    = rd_q;
    wr_n    = wr_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rdata_n = rdata_q;
    cnt_n   = cnt_q;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    last_n  = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|bus.m_req) begin
          state_n = ST_ACCESS;
          gnt_n   = winner;
          addr_n  = win_idx ? bus.m_addr[2*ADDR_W-1:ADDR_W] : bus.m_addr[ADDR_W-1:0];
          wdata_n = win_idx ? bus.m_wdata[2*DATA_W-1:DATA_W] : bus.m_wdata[DATA_W-1:0];
          rd_n    = ~bus.m_we[win_idx];
          wr_n    = bus.m_we[win_idx];
          cnt_n   = '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
          last_n  = win_idx;
`endif
        end
      end
      ST_ACCESS: begin
        // A ready arriving on the last allowed cycle still completes normally
        if (bus.mem_ready) begin
          state_n = ST_DONE;
          done_n  = gnt_q;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          if (rd_q) begin
            rdata_n = bus.mem_rdata;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_n = ST_DONE;
          done_n  = gnt_q;
          err_n   = 1'b1;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          rdata_n = {DATA_W{1'b1}};
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        rd_n    = 1'b0;
        wr_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      done_q  <= done_n;
      err_q   <= err_n;
      rd_q    <= rd_n;
      wr_q    <= wr_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      rdata_q <= rdata_n;
      cnt_q   <= cnt_n;
    end
  end

`ifdef BUS_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_n;
    end
  end
`endif

  assign bus.m_gnt     = gnt_q;
  assign bus.m_done    = done_q;
  assign bus.m_err     = err_q;
  assign bus.m_rdata   = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_r     = rd_q;
  assign bus.mem_w     = wr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (honours BUS_ARB_ROUND_ROBIN_EN).
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int TO          = 15;
  localparam int RAND_CYCLES = 2000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  bus_arbiter_if bus ();

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [6:0] ctl;
  assign ctl = {bus.m_gnt, bus.m_done, bus.m_err, bus.mem_r, bus.mem_w};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.m_req     = '0;
    bus.m_we      = '0;
    bus.m_addr    = '0;
    bus.m_wdata   = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.m_req     = 2'b11;
    bus.m_we      = 2'b01;
    bus.m_addr    = 32'hDEAD_BEEF;
    bus.m_wdata   = 16'h55AA;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 8'h77;
    repeat (3) tick();
    n_checks++;
    if ({ctl, bus.mem_addr, bus.mem_wdata, bus.m_rdata} !== 39'h0)
      $display("FAIL reset_hold: got ctl=%b addr=%h wd=%h rd=%h, expected all zero",
               ctl, bus.mem_addr, bus.mem_wdata, bus.m_rdata);
    else n_pass++;
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({ctl, bus.mem_addr, bus.m_rdata} !== 31'h0)
      $display("FAIL reset_release: got ctl=%b addr=%h rd=%h, expected zero", ctl, bus.mem_addr, bus.m_rdata);
    else n_pass++;
  endtask

  task automatic test_cpu_read();
    bus.m_req     = 2'b01;
    bus.m_we      = 2'b00;
    bus.m_addr    = {16'h0000, 16'h2000};
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 8'h3C;
    tick();
    n_checks++;
    if ({ctl, bus.mem_addr} !== {7'b01_00_0_1_0, 16'h2000})
      $display("FAIL cpu_read_grant: got ctl=%b addr=%h, expected 0100010 2000", ctl, bus.mem_addr);
    else n_pass++;
    bus.m_req = 2'b00;
    tick();
    n_checks++;
    if ({ctl, bus.m_rdata} !== {7'b01_01_0_0_0, 8'h3C})
      $display("FAIL cpu_read_done: got ctl=%b rd=%h, expected 0101000 3c", ctl, bus.m_rdata);
    else n_pass++;
    tick();
    n_checks++;
    if (ctl !== 7'b0)
      $display("FAIL cpu_read_idle: got ctl=%b, expected 0000000", ctl);
    else n_pass++;
    tick();
    n_checks++;
    if ({ctl, bus.m_rdata} !== {7'b0, 8'h3C})
      $display("FAIL stray_ready_idle: got ctl=%b rd=%h, expected 0000000 3c", ctl, bus.m_rdata);
    else n_pass++;
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_both();
    logic [1:0] exp_g;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    exp_g = 2'b10;
`else
    exp_g = 2'b01;
`endif
    do_reset();
    bus.m_req     = 2'b11;
    bus.m_we      = 2'b10;
    bus.m_addr    = {16'h8000, 16'h1234};
    bus.m_wdata   = {8'hA5, 8'h00};
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 8'h5A;
    tick();
    n_checks++;
    if ({ctl, bus.mem_addr} !== {7'b01_00_0_1_0, 16'h1234})
      $display("FAIL both_first_cpu: got ctl=%b addr=%h, expected 0100010 1234", ctl, bus.mem_addr);
    else n_pass++;
    bus.m_req = 2'b10;
    tick();
    n_checks++;
    if ({ctl, bus.m_rdata} !== {7'b01_01_0_0_0, 8'h5A})
      $display("FAIL both_cpu_done: got ctl=%b rd=%h, expected 0101000 5a", ctl, bus.m_rdata);
    else n_pass++;
    tick();
    n_checks++;
    if (ctl !== 7'b0)
      $display("FAIL both_gap: got ctl=%b, expected 0000000", ctl);
    else n_pass++;
    tick();
    n_checks++;
    if ({ctl, bus.mem_addr, bus.mem_wdata} !== {7'b10_00_0_0_1, 16'h8000, 8'hA5})
      $display("FAIL both_dma_grant: got ctl=%b addr=%h wd=%h, expected 1000001 8000 a5",
               ctl, bus.mem_addr, bus.mem_wdata);
    else n_pass++;
    bus.mem_rdata = 8'hC3;
    bus.m_req     = 2'b01;
    tick();
    n_checks++;
    if ({ctl, bus.m_rdata} !== {7'b10_10_0_0_0, 8'h5A})
      $display("FAIL both_dma_done: got ctl=%b rd=%h, expected 1010000 5a", ctl, bus.m_rdata);
    else n_pass++;
    bus.m_req = 2'b11;
    tick();
    tick();
    n_checks++;
    if (ctl !== 7'b01_00_0_1_0)
      $display("FAIL both_cpu_again: got ctl=%b, expected 0100010", ctl);
    else n_pass++;
    tick();
    n_checks++;
    if ({ctl, bus.m_rdata} !== {7'b01_01_0_0_0, 8'hC3})
      $display("FAIL both_cpu_again_done: got ctl=%b rd=%h, expected 0101000 c3", ctl, bus.m_rdata);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (ctl !== {exp_g, 2'b00, 1'b0, exp_g == 2'b01, exp_g == 2'b10})
      $display("FAIL both_policy: got ctl=%b, expected gnt %b", ctl, exp_g);
    else n_pass++;
    bus.m_req = 2'b00;
    tick();
    tick();
    n_checks++;
    if (ctl !== 7'b0)
      $display("FAIL both_drain: got ctl=%b, expected 0000000", ctl);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bus.mem_ready = 1'b0;
    bus.m_req     = 2'b01;
    bus.m_we      = 2'b00;
    bus.m_addr    = {16'h0000, 16'h0BEE};
    tick();
    for (int i = 1; i < TO; i++) begin
      bus.m_req  = 2'($urandom);
      bus.m_addr = $urandom;
      tick();
      n_checks++;
      if ({ctl, bus.mem_addr} !== {7'b01_00_0_1_0, 16'h0BEE})
        $display("FAIL timeout_wait[%0d]: got ctl=%b addr=%h, expected 0100010 0bee", i, ctl, bus.mem_addr);
      else n_pass++;
    end
    bus.m_req = 2'b00;
    tick();
    n_checks++;
    if ({ctl, bus.m_rdata} !== {7'b01_01_1_0_0, 8'hFF})
      $display("FAIL timeout_done: got ctl=%b rd=%h, expected 0101100 ff", ctl, bus.m_rdata);
    else n_pass++;
    tick();
    n_checks++;
    if (ctl !== 7'b0)
      $display("FAIL timeout_idle: got ctl=%b, expected 0000000", ctl);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    bus.mem_ready = 1'b0;
    bus.m_req     = 2'b01;
    bus.m_we      = 2'b00;
    bus.m_addr    = {16'h0000, 16'h4321};
    bus.mem_rdata = 8'h9D;
    repeat (3) tick();
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    n_checks++;
    if ({ctl, bus.mem_addr, bus.mem_wdata, bus.m_rdata} !== 39'h0)
      $display("FAIL reset_mid_async: got ctl=%b addr=%h wd=%h rd=%h, expected all zero",
               ctl, bus.mem_addr, bus.mem_wdata, bus.m_rdata);
    else n_pass++;
    tick();
    n_checks++;
    if (ctl !== 7'b0)
      $display("FAIL reset_mid_no_done: got ctl=%b, expected 0000000", ctl);
    else n_pass++;
    #2;
    reset = 1'b1;
    tick();
    n_checks++;
    if ({ctl, bus.mem_addr} !== {7'b01_00_0_1_0, 16'h4321})
      $display("FAIL reset_mid_regrant: got ctl=%b addr=%h, expected 0100010 4321", ctl, bus.mem_addr);
    else n_pass++;
    bus.m_req = 2'b00;
    tick();
    n_checks++;
    if ({ctl, bus.m_rdata} !== {7'b01_01_0_0_0, 8'h9D})
      $display("FAIL reset_mid_done: got ctl=%b rd=%h, expected 0101000 9d", ctl, bus.m_rdata);
    else n_pass++;
    bus.mem_ready = 1'b0;
    tick();
  endtask

  // Transaction-level model: a grant occupies the bus from grant to completion,
  // then one DONE-exit cycle passes before the next grant can be made.
  task automatic test_random();
    int owner, g_cyc, d_cyc, lat, earliest, last, w, r;
    bit pend [2];
    int idle_w [2];
    logic [15:0] op_a [2];
    logic        op_we [2];
    logic [7:0]  op_wd [2];
    logic [15:0] x_addr;
    logic        x_we, timeout, in_acc;
    logic [7:0]  x_wd, x_rdata, tr_rd;
    logic [1:0]  oh, req_v, we_v;
    logic [31:0] a_v;
    logic [15:0] wd_v;
    logic [6:0]  exp_ctl;

    do_reset();
    owner = -1; earliest = 0; last = 1; g_cyc = 0; d_cyc = 0; lat = 0;
    x_addr = '0; x_we = 1'b0; x_wd = '0; x_rdata = '0; tr_rd = '0; timeout = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pend[i]   = 1'b0;
      idle_w[i] = $urandom_range(0, 3);
      op_a[i]   = '0;
      op_we[i]  = 1'b0;
      op_wd[i]  = '0;
    end

    for (int t = 1; t <= RAND_CYCLES; t++) begin
      tick();
      if (owner >= 0 && t > d_cyc) owner = -1;
      if (owner < 0 && t >= earliest && bus.m_req != 2'b00) begin
        if (bus.m_req == 2'b11) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
          w = (last == 1) ? 0 : 1;
`else
          w = 0;
`endif
        end else begin
          w = bus.m_req[0] ? 0 : 1;
        end
        owner   = w;
        last    = w;
        pend[w] = 1'b0;
        g_cyc   = t;
        x_addr  = op_a[w];
        x_we    = op_we[w];
        x_wd    = op_wd[w];
        r       = int'($urandom % 8);
        lat     = (r == 0) ? TO + int'($urandom % 3) : (r == 1) ? TO - 1 : int'($urandom % 4);
        tr_rd   = 8'($urandom);
        timeout = (lat > TO - 1);
        d_cyc   = timeout ? t + TO : t + lat + 1;
        earliest = d_cyc + 2;
      end

      in_acc  = (owner >= 0) && (t < d_cyc);
      oh      = (owner == 1) ? 2'b10 : 2'b01;
      exp_ctl = '0;
      if (owner >= 0) begin
        exp_ctl[6:5] = oh;
        if (t == d_cyc) begin
          exp_ctl[4:3] = oh;
          exp_ctl[2]   = timeout;
          if (timeout) x_rdata = 8'hFF;
          else if (!x_we) x_rdata = tr_rd;
        end
      end
      if (in_acc) begin
        exp_ctl[1] = !x_we;
        exp_ctl[0] = x_we;
      end

      n_checks++;
      if (ctl !== exp_ctl)
        $display("FAIL rand_ctl t=%0d: got %b expected %b", t, ctl, exp_ctl);
      else n_pass++;
      n_checks++;
      if ({bus.mem_addr, bus.mem_wdata, bus.m_rdata} !== {x_addr, x_wd, x_rdata})
        $display("FAIL rand_data t=%0d: got addr=%h wd=%h rd=%h expected %h %h %h",
                 t, bus.mem_addr, bus.mem_wdata, bus.m_rdata, x_addr, x_wd, x_rdata);
      else n_pass++;

      if (owner >= 0 && t == d_cyc) idle_w[owner] = $urandom_range(0, 3);

      if (in_acc) begin
        bus.mem_ready = ((t - g_cyc) >= lat);
        bus.mem_rdata = tr_rd;
      end else begin
        bus.mem_ready = 1'($urandom);
        bus.mem_rdata = 8'($urandom);
      end

      for (int i = 0; i < 2; i++) begin
        if (owner == i && in_acc) begin
          req_v[i]         = 1'($urandom);
          we_v[i]          = 1'($urandom);
          a_v[i*16 +: 16]  = 16'($urandom);
          wd_v[i*8 +: 8]   = 8'($urandom);
        end else begin
          if (!pend[i]) begin
            if (idle_w[i] > 0) begin
              idle_w[i]--;
            end else begin
              pend[i]  = 1'b1;
              op_a[i]  = 16'($urandom);
              op_we[i] = 1'($urandom);
              op_wd[i] = 8'($urandom);
            end
          end
          req_v[i]        = pend[i];
          we_v[i]         = op_we[i];
          a_v[i*16 +: 16] = op_a[i];
          wd_v[i*8 +: 8]  = op_wd[i];
        end
      end
      bus.m_req   = req_v;
      bus.m_we    = we_v;
      bus.m_addr  = a_v;
      bus.m_wdata = wd_v;
    end

    bus.m_req     = 2'b00;
    bus.mem_ready = 1'b1;
    repeat (TO + 4) tick();
    n_checks++;
    if (ctl !== 7'b0)
      $display("FAIL rand_drain: got ctl=%b, expected 0000000", ctl);
    else n_pass++;
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_cpu_read();
    test_both();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving the maximum number of ACCESS-state cycles spent waiting for mem_ready (range 1..255).
REQ-002 SHALL have port clk  in  1  system clock; all state changes on posedge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port m_req  in  2  per-master request (bit0 = CPU, bit1 = DMA).
REQ-005 SHALL have port m_we  in  2  per-master write enable (1 = write, 0 = read).
REQ-006 SHALL have port m_addr  in  32  per-master address (bits [15:0] = master 0, bits [31:16] = master 1).
REQ-007 SHALL have port m_wdata  in  16  per-master write data (bits [7:0] = master 0, bits [15:8] = master 1).
REQ-008 SHALL have port m_gnt  out  2  one-hot grant, held from grant through completion.
REQ-009 SHALL have port m_done  out  2  one-cycle completion pulse to the granted master.
REQ-010 SHALL have port m_rdata  out  8  read data, valid while m_done is high.
REQ-011 SHALL have port m_err  out  1  one-cycle pulse, coincident with m_done, flagging a timeout.
REQ-012 SHALL have port mem_addr  out  16  memory address.
REQ-013 SHALL have port mem_wdata  out  8  memory write data.
REQ-014 SHALL have port mem_rdata  in  8  memory read data.
REQ-015 SHALL have ports mem_r and mem_w  out  1 each  read and write strobes, mutually exclusive.
REQ-016 SHALL have port mem_ready  in  1  memory completion, sampled only in ACCESS.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, ACCESS, DONE.
REQ-018 In IDLE with any m_req bit high, SHALL at the next edge latch the winner's addr/we/wdata, assert its m_gnt bit, assert mem_r or mem_w, clear the wait counter and enter ACCESS.
REQ-019 In ACCESS, mem_addr and mem_wdata SHALL be held constant from the latched values, independent of master inputs.
REQ-020 In ACCESS with mem_ready high, SHALL at the next edge enter DONE, drop the strobes, pulse m_done[winner], and present mem_rdata on m_rdata (reads only; writes leave m_rdata unchanged).
REQ-021 In ACCESS with mem_ready low, the wait counter SHALL increment each cycle; when it reaches TIMEOUT, SHALL enter DONE with m_done[winner]=1, m_err=1, m_rdata=8'hFF.
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE and deassert m_gnt; minimum request-to-done latency is 2 cycles (mem_ready already high); back-to-back grants are separated by one idle cycle.
REQ-023 Deassertion of m_req during ACCESS SHALL NOT abort the transfer.
REQ-024 mem_ready high while not in ACCESS SHALL be ignored.
REQ-025 Simultaneous requests SHALL be resolved per REQ-029/REQ-030; a loser keeps waiting with no loss of its request.

Reset
REQ-026 While reset is low: state IDLE; m_gnt, m_done, m_err, mem_r, mem_w = 0; mem_addr = 16'h0000; mem_wdata, m_rdata = 8'h00; wait counter 0; last-grant pointer = 1.
REQ-027 Reset asserted mid-ACCESS SHALL abandon the transfer immediately, asynchronously, with no m_done pulse.

Configuration
REQ-028 Macro BUS_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-029 With BUS_ARB_ROUND_ROBIN_EN defined: when both request, the master not granted last wins; the pointer updates on each grant.
REQ-030 Without BUS_ARB_ROUND_ROBIN_EN: fixed priority, master 0 (CPU) always wins; the pointer logic is not built.

Structure
REQ-031 Package bus_arb_pkg SHALL hold the FSM state enum, the master-index typedef, NUM_MASTERS=2 and TIMEOUT_DEFAULT=15.
REQ-032 Winner selection SHALL be a sub-module bus_arb_pick (inputs: req, last pointer; output: one-hot winner).

Verification
REQ-033 CPU read 16'h2000, mem_ready high at first ACCESS cycle, mem_rdata=8'h3C -> m_gnt=01 next cycle, m_done=01 with m_rdata=8'h3C two cycles after request.
REQ-034 Both request, DMA write 8'hA5 to 16'h8000 -> fixed priority: CPU first, then DMA after the DONE cycle; round-robin (after reset): CPU, then DMA, then CPU on re-request.
REQ-035 mem_ready held low, TIMEOUT=15 -> after 15 ACCESS cycles m_done and m_err pulse together with m_rdata=8'hFF, then FSM returns to IDLE.
REQ-036 Reset pulsed low at cycle 3 of ACCESS -> all outputs zero immediately, no m_done; a request after release is granted normally.
REQ-037 Requester drops m_req in ACCESS; stray mem_ready in IDLE -> transfer still completes with m_done; stray ready causes no state change.
